// File: rtl/anc_stream_if.sv
// Core-side sample handshake: head-of-FIFO sample set out, core result back in.
interface anc_stream_if #(
   parameter int W = 16
);
   logic                in_valid;
   logic                controller_ready;
   logic signed [W-1:0] x_in;
   logic signed [W-1:0] e_in;
   logic signed [W-1:0] a_in;
   logic signed [W-1:0] u_in;
   logic signed [W-1:0] out_sample;
   logic                out_valid;

   modport master (
      output in_valid, x_in, e_in, a_in, u_in,
      input  controller_ready, out_sample, out_valid
   );

   modport slave (
      input  in_valid, x_in, e_in, a_in, u_in,
      output controller_ready, out_sample, out_valid
   );
endinterface

// File: rtl/anc_stream_io.sv
// Serial ADC deserializer + sample-set FIFO toward the ANC core, and
// DAC-side hold/serializer for the core output.
module anc_stream_io #(
   parameter int W     = 16,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bit_en,
   input  logic         fs,
   input  logic         sdi_x,
   input  logic         sdi_e,
   input  logic         sdi_a,
   input  logic [W-1:0] u_cfg,
   anc_stream_if.master core,
   output logic         sdo,
   input  logic         clr_status,
   output logic         overrun,
   output logic         underrun,
   output logic         frame_err
);
   localparam int CW   = $clog2(W);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_e;

   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  xs_q, xs_d, es_q, es_d, as_q, as_d;
   logic [W-1:0]  px, pe, pa;
   logic          push, ferr_set;

   logic [W-1:0]    mx_q [DEPTH];
   logic [W-1:0]    me_q [DEPTH];
   logic [W-1:0]    ma_q [DEPTH];
   logic [W-1:0]    mu_q [DEPTH];
   logic [AW-1:0]   wp_q, rp_q;
   logic [CNTW-1:0] count_q, count_d;
   logic            iv_q, pop, full, wr_en, ovr_set;

   logic [W-1:0] hold_q, hold_d, tsr_q, tsr_d;
   logic         hn_q, hn_d, udr_set;
   logic         ovr_q, udr_q, ferr_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      xs_d     = xs_q;
      es_d     = es_q;
      as_d     = as_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      px       = {xs_q[W-2:0], sdi_x};
      pe       = {es_q[W-2:0], sdi_e};
      pa       = {as_q[W-2:0], sdi_a};
      if (bit_en) begin
         unique case (state_q)
            RX_IDLE: begin
               if (fs) begin
                  xs_d    = px;
                  es_d    = pe;
                  as_d    = pa;
                  cnt_d   = CW'(1);
                  state_d = RX_SHIFT;
               end
            end
            RX_SHIFT: begin
               xs_d = px;
               es_d = pe;
               as_d = pa;
               // fs on the completing bit still completes; earlier fs restarts the word
               if (fs && cnt_q != CW'(W-1)) begin
                  ferr_set = 1'b1;
                  cnt_d    = CW'(1);
               end else if (cnt_q == CW'(W-1)) begin
                  push    = 1'b1;
                  cnt_d   = '0;
                  state_d = RX_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end

   assign pop     = iv_q && core.controller_ready;
   assign full    = (count_q == CNTW'(DEPTH));
   assign wr_en   = push && (!full || pop);
   assign ovr_set = push && full && !pop;
   assign count_d = count_q + CNTW'(wr_en) - CNTW'(pop);

   always_comb begin
      hold_d  = hold_q;
      hn_d    = hn_q;
      tsr_d   = tsr_q;
      udr_set = 1'b0;
      if (bit_en && fs) begin
         tsr_d   = hold_q;
         hn_d    = 1'b0;
         udr_set = !hn_q;
      end else if (bit_en) begin
         tsr_d = {tsr_q[W-2:0], 1'b0};
      end
      if (core.out_valid) begin
         hold_d = core.out_sample;
         hn_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         xs_q    <= '0;
         es_q    <= '0;
         as_q    <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         iv_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mx_q[i] <= '0;
            me_q[i] <= '0;
            ma_q[i] <= '0;
            mu_q[i] <= '0;
         end
         hold_q <= '0;
         hn_q   <= 1'b0;
         tsr_q  <= '0;
         ovr_q  <= 1'b0;
         udr_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         xs_q    <= xs_d;
         es_q    <= es_d;
         as_q    <= as_d;
         if (wr_en) begin
            mx_q[wp_q] <= px;
            me_q[wp_q] <= pe;
            ma_q[wp_q] <= pa;
            mu_q[wp_q] <= u_cfg;
            wp_q       <= wp_q + 1'b1;
         end
         if (pop) rp_q <= rp_q + 1'b1;
         count_q <= count_d;
         // valid rises one clock after a push but drops on the popping edge
         iv_q    <= (count_q != '0) && (count_d != '0);
         hold_q  <= hold_d;
         hn_q    <= hn_d;
         tsr_q   <= tsr_d;
         ovr_q   <= ovr_set  | (ovr_q  & ~clr_status);
         udr_q   <= udr_set  | (udr_q  & ~clr_status);
         ferr_q  <= ferr_set | (ferr_q & ~clr_status);
      end
   end

   assign core.in_valid = iv_q;
   assign core.x_in     = mx_q[rp_q];
   assign core.e_in     = me_q[rp_q];
   assign core.a_in     = ma_q[rp_q];
   assign core.u_in     = mu_q[rp_q];
   assign sdo           = tsr_q[W-1];
   assign overrun       = ovr_q;
   assign underrun      = udr_q;
   assign frame_err     = ferr_q;
endmodule

// File: tb/tb_anc_stream_io.sv
// Scoreboard bench for anc_stream_io: stimulus queues expected sample sets and
// DAC bits; a monitor compares them as the DUT presents them.
module tb_anc_stream_io;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst, bit_en, fs, sdi_x, sdi_e, sdi_a, clr_status;
   logic [W-1:0] u_cfg;
   logic         sdo, overrun, underrun, frame_err;
   logic         be_s = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] rxq[$];
   logic        txq[$];

   anc_stream_if #(.W(W)) bus ();

   anc_stream_io #(.W(W), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .fs         (fs),
      .sdi_x      (sdi_x),
      .sdi_e      (sdi_e),
      .sdi_a      (sdi_a),
      .u_cfg      (u_cfg),
      .core       (bus),
      .sdo        (sdo),
      .clr_status (clr_status),
      .overrun    (overrun),
      .underrun   (underrun),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) be_s <= bit_en;

   always @(negedge clk) begin
      if (bus.in_valid && bus.controller_ready) begin
         if (rxq.size() == 0) chk("unexpected_pop", bus.in_valid, 0);
         else chk("rx_set", {bus.x_in, bus.e_in, bus.a_in, bus.u_in}, rxq.pop_front());
      end
      if (be_s && txq.size() != 0) chk("sdo_bit", sdo, txq.pop_front());
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit_en = 1'b0;
      fs     = 1'b0;
      repeat (n) step();
   endtask

   task automatic trail(input int n);
      bit_en = 1'b1;
      fs     = 1'b0;
      repeat (n) step();
      bit_en = 1'b0;
   endtask

   task automatic send_bits(input logic [W-1:0] x, e, a, u, input int nb);
      for (int i = 0; i < nb; i++) begin
         bit_en = 1'b1;
         fs     = (i == 0);
         sdi_x  = x[W-1-i];
         sdi_e  = e[W-1-i];
         sdi_a  = a[W-1-i];
         u_cfg  = u;
         step();
      end
      bit_en = 1'b0;
      fs     = 1'b0;
   endtask

   task automatic exp_tx(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) txq.push_back(w[W-1-i]);
      txq.push_back(1'b0);
      txq.push_back(1'b0);
   endtask

   task automatic clear_flags();
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      @(negedge clk);
      chk({tag, "_in_valid"}, bus.in_valid, 0);
      chk({tag, "_x_in"}, bus.x_in, 0);
      chk({tag, "_e_in"}, bus.e_in, 0);
      chk({tag, "_a_in"}, bus.a_in, 0);
      chk({tag, "_u_in"}, bus.u_in, 0);
      chk({tag, "_sdo"}, sdo, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_underrun"}, underrun, 0);
      chk({tag, "_frame_err"}, frame_err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; bit_en = 1'b0; fs = 1'b0; sdi_x = 1'b0; sdi_e = 1'b0; sdi_a = 1'b0;
      clr_status = 1'b0; u_cfg = '0;
      bus.controller_ready = 1'b0; bus.out_valid = 1'b0; bus.out_sample = '0;
      step(); step();
      check_zero("reset");
      rst = 1'b0;
      step();

      // 1: single frame, in_valid one-cycle pulse one clock after the last bit
      bus.controller_ready = 1'b1;
      rxq.push_back({16'h1234, 16'hFFFE, 16'h8000, 16'h0100});
      send_bits(16'h1234, 16'hFFFE, 16'h8000, 16'h0100, 16);
      @(negedge clk); chk("t1_iv_at_edge", bus.in_valid, 0);
      @(negedge clk); chk("t1_iv_pulse", bus.in_valid, 1);
      @(negedge clk); chk("t1_iv_fall", bus.in_valid, 0);
      step();

      // 2: backpressure, FIFO full, third frame lost
      bus.controller_ready = 1'b0;
      rxq.push_back({16'h1111, 16'h2222, 16'h3333, 16'h0001});
      rxq.push_back({16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0002});
      send_bits(16'h1111, 16'h2222, 16'h3333, 16'h0001, 16);
      send_bits(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0002, 16);
      send_bits(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0003, 16);
      idle(2);
      @(negedge clk);
      chk("t2_iv_held", bus.in_valid, 1);
      chk("t2_overrun", overrun, 1);
      chk("t2_head_x", bus.x_in, 16'h1111);
      chk("t2_head_u", bus.u_in, 16'h0001);
      step();
      bus.controller_ready = 1'b1;
      for (int i = 0; i < 10 && rxq.size() != 0; i++) step();
      idle(2);
      chk("t2_drained", rxq.size(), 0);
      @(negedge clk); chk("t2_iv_empty", bus.in_valid, 0);
      step();
      clear_flags();
      @(negedge clk); chk("t2_overrun_clr", overrun, 0);
      step();

      // 3: fs reasserted after 7 bits
      send_bits(16'h7F00, 16'h00FF, 16'h5555, 16'h0009, 7);
      rxq.push_back({16'h0F0F, 16'h8001, 16'h7FFF, 16'h0004});
      send_bits(16'h0F0F, 16'h8001, 16'h7FFF, 16'h0004, 16);
      idle(4);
      chk("t3_delivered", rxq.size(), 0);
      @(negedge clk); chk("t3_frame_err", frame_err, 1);
      step();
      clear_flags();
      @(negedge clk);
      chk("t3_ferr_clr", frame_err, 0);
      chk("t3_udr_clr", underrun, 0);
      step();

      // 4: serialize 0xA5C3
      bus.out_sample = 16'hA5C3;
      bus.out_valid  = 1'b1;
      step();
      bus.out_valid = 1'b0;
      idle(1);
      exp_tx(16'hA5C3);
      rxq.push_back({16'h0001, 16'h0002, 16'h0003, 16'h0005});
      send_bits(16'h0001, 16'h0002, 16'h0003, 16'h0005, 16);
      trail(2);
      idle(3);
      chk("t4_tx_done", txq.size(), 0);
      chk("t4_rx_done", rxq.size(), 0);
      @(negedge clk); chk("t4_no_underrun", underrun, 0);
      step();

      // 5: no new out_valid, stale word resent
      exp_tx(16'hA5C3);
      rxq.push_back({16'hFFFF, 16'h0000, 16'h8001, 16'h0006});
      send_bits(16'hFFFF, 16'h0000, 16'h8001, 16'h0006, 16);
      trail(2);
      idle(3);
      chk("t5_tx_done", txq.size(), 0);
      @(negedge clk); chk("t5_underrun", underrun, 1);
      step();
      clear_flags();
      @(negedge clk); chk("t5_udr_clr", underrun, 0);
      step();

      // 6: reset at bit 9 with one set buffered
      bus.controller_ready = 1'b0;
      send_bits(16'h1357, 16'h2468, 16'h9ABC, 16'h0007, 16);
      idle(2);
      @(negedge clk); chk("t6_buffered", bus.in_valid, 1);
      step();
      send_bits(16'hFEDC, 16'hBA98, 16'h7654, 16'h0008, 9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_zero("t6_rst");
      step();
      bus.controller_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("t6_no_iv", bus.in_valid, 0);
      end
      step();
      rxq.push_back({16'h4321, 16'h0FF0, 16'hC001, 16'h000A});
      send_bits(16'h4321, 16'h0FF0, 16'hC001, 16'h000A, 16);
      idle(4);
      chk("t6_recovered", rxq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
